core_link_monitor: RTL



---
 rtl/core_link_monitor.sv | 137 +++++++++++++
 1 files changed

// File: rtl/core_link_monitor.sv
// core_link_monitor: link-acquisition FSM with saturating error/drop statistics behind a 5-bit CPU register bus
//   clock, reset                 : symbol clock, synchronous active-high reset
//   test_enable                  : holds FSM in HUNT and freezes counters, last_data, irq_stat
//   core_data/code_error/idle    : per-cycle symbol from the receive stage
//   cpu_wr/addr/wdata, cpu_rdata : register bus, read data registered one cycle after address
//   link_up, err_irq             : link status and registered level interrupt
module core_link_monitor #(
   parameter int SYNC_IDLES = 4,
   parameter int ERR_LIMIT  = 4,
   parameter int ERR_WINDOW = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       test_enable,
   input  logic [7:0] core_data,
   input  logic       core_code_error,
   input  logic       core_code_idle,
   input  logic       cpu_wr,
   input  logic [4:0] cpu_addr,
   input  logic [7:0] cpu_wdata,
   output logic [7:0] cpu_rdata,
   output logic       link_up,
   output logic       err_irq
);
   localparam int WW = $clog2(ERR_WINDOW);
   typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, UP = 2'd2} state_t;
   state_t state, state_n;
   logic [3:0] idle_cnt, idle_cnt_n, win_err, win_err_n, win_base;
   logic [WW-1:0] win_cnt, win_cnt_n;
   logic [15:0] err_cnt;
   logic [7:0] drop_cnt, last_data, rd_mux;
   logic [1:0] irq_stat;
   logic irq_en;
   logic is_err, is_idle, is_data, wr_ctrl, wr_irq, wr_clr, force_hunt;
   logic wrap, err_drop, drop, sat_ev;
   logic unused_wdata;
   assign is_err     = core_code_error;
   assign is_idle    = !core_code_error && core_code_idle;
   assign is_data    = !core_code_error && !core_code_idle;
   assign wr_ctrl    = cpu_wr && cpu_addr == 5'h05;
   assign wr_irq     = cpu_wr && cpu_addr == 5'h06;
   assign wr_clr     = cpu_wr && cpu_addr == 5'h07 && cpu_wdata[0];
   assign force_hunt = wr_ctrl && cpu_wdata[0];
   assign unused_wdata = ^cpu_wdata[7:2];
   // an error in the wrap cycle belongs to the new window, so the base count restarts at zero
   assign wrap     = &win_cnt;
   assign win_base = wrap ? 4'd0 : win_err;
   assign err_drop = state == UP && is_err && (win_base + 4'd1 == 4'(ERR_LIMIT));
   assign drop     = !test_enable && state == UP && (force_hunt || err_drop);
   // saturation event is the single increment into 0xFFFF; a clear in the same cycle wins over counting past it
   assign sat_ev   = !test_enable && !wr_clr && is_err && err_cnt == 16'hFFFE;
   assign link_up  = state == UP;
   always_comb begin
      state_n    = state;
      idle_cnt_n = idle_cnt;
      win_cnt_n  = win_cnt;
      win_err_n  = win_err;
      case (state)
         HUNT: begin
            if (is_idle) begin
               state_n    = CHECK;
               idle_cnt_n = 4'd1;
            end
         end
         CHECK: begin
            if (!is_idle) begin
               state_n    = HUNT;
               idle_cnt_n = 4'd0;
            end else if (idle_cnt + 4'd1 == 4'(SYNC_IDLES)) begin
               state_n   = UP;
               win_cnt_n = '0;
               win_err_n = 4'd0;
            end else begin
               idle_cnt_n = idle_cnt + 4'd1;
            end
         end
         UP: begin
            win_cnt_n = win_cnt + 1'b1;
            win_err_n = win_base + {3'b0, is_err};
            if (err_drop) begin
               state_n    = HUNT;
               idle_cnt_n = 4'd0;
            end
         end
         default: state_n = HUNT;
      endcase
      if (test_enable || force_hunt) begin
         state_n    = HUNT;
         idle_cnt_n = 4'd0;
      end
   end
   always_comb begin
      rd_mux = 8'h00;
      case (cpu_addr)
         5'h00:   rd_mux = {5'b0, state, link_up};
         5'h01:   rd_mux = err_cnt[7:0];
         5'h02:   rd_mux = err_cnt[15:8];
         5'h03:   rd_mux = drop_cnt;
         5'h04:   rd_mux = last_data;
         5'h05:   rd_mux = {6'b0, irq_en, 1'b0};
         5'h06:   rd_mux = {6'b0, irq_stat};
         default: rd_mux = 8'h00;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= HUNT;
         idle_cnt  <= 4'd0;
         win_cnt   <= '0;
         win_err   <= 4'd0;
         err_cnt   <= 16'h0000;
         drop_cnt  <= 8'h00;
         last_data <= 8'h00;
         irq_stat  <= 2'b00;
         irq_en    <= 1'b0;
         err_irq   <= 1'b0;
         cpu_rdata <= 8'h00;
      end else begin
         state     <= state_n;
         idle_cnt  <= idle_cnt_n;
         win_cnt   <= win_cnt_n;
         win_err   <= win_err_n;
         cpu_rdata <= rd_mux;
         err_irq   <= irq_en & |irq_stat;
         if (wr_ctrl) irq_en <= cpu_wdata[1];
         if (!test_enable) begin
            if (wr_clr) err_cnt <= {15'b0, is_err};
            else if (is_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (wr_clr) drop_cnt <= {7'b0, drop};
            else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            if (state == UP && is_data) last_data <= core_data;
            // set events override a simultaneous write-one-to-clear
            irq_stat <= (irq_stat & ~(wr_irq ? cpu_wdata[1:0] : 2'b00)) | {sat_ev, drop};
         end
      end
   end
endmodule
